phase_pair_sequencer: RTL and testbench

// - Two-round scheduler for the phase-vector index-pairing datapath: sweeps the phase-vector register array,

---
 rtl/phase_pair_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_phase_pair_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_pair_sequencer.sv
// phase_pair_sequencer
// Two-round scheduler for the phase-vector index-pairing datapath.
// Round one sweeps the phase-vector array and feeds the index-write stream.
// It then waits for the alpha write to finish.
// Round two replays the array and collects the returned matches into a pair FIFO.
// Round-two issues are throttled by a credit count, so the FIFO cannot overflow.
// Optional feature: define PAIR_COUNT_EN to add the pair_count output.
// pair_count counts the pairs pushed during the current sweep.

module phase_pair_sequencer #(
    parameter int num_qubit  = 3,
    parameter int PAIR_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [num_qubit:0]   num_vec,
    input  logic                 done_alpha,
    output logic                 arr_rd_en,
    output logic [num_qubit-1:0] arr_rd_addr,
    output logic                 wr_phase,
    output logic                 rd_phase,
    input  logic                 match_valid,
    input  logic [num_qubit-1:0] match_index,
    output logic                 pair_valid,
    input  logic                 pair_ready,
    output logic [num_qubit-1:0] pair_first,
    output logic [num_qubit-1:0] pair_second,
    output logic                 busy,
    output logic                 sweep_done
`ifdef PAIR_COUNT_EN
    ,
    output logic [num_qubit:0]   pair_count
`endif
);

    localparam int VW    = num_qubit + 1;
    localparam int PTR_W = (PAIR_DEPTH > 1) ? $clog2(PAIR_DEPTH) : 1;
    localparam int CNT_W = $clog2(PAIR_DEPTH + 1);
    localparam int ENT_W = 2 * num_qubit;
    localparam logic [num_qubit:0] MAX_ROWS = {1'b1, {num_qubit{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_R1,
        S_WAIT,
        S_GAP,
        S_R2,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [VW-1:0]         row_cnt;
    logic [VW-1:0]         n_rows;
    logic [VW-1:0]         num_clamped;
    logic                  last_row;
    logic                  issue_r1;
    logic                  issue_r2;
    logic [CNT_W-1:0]      credit;
    logic [RD_LAT:0]       pipe_vld;
    logic [num_qubit-1:0]  pipe_row [RD_LAT+1];
    logic                  resp_vld;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  in_flight;
    logic [ENT_W-1:0]      fifo_mem [PAIR_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;

    assign num_clamped = (num_vec > MAX_ROWS) ? MAX_ROWS : num_vec;
    assign last_row    = (row_cnt == n_rows - VW'(1));

    // The response for an issued row sits at the end of the row pipeline.
    // A pair is pushed only when that response is a match.
    assign resp_vld  = pipe_vld[RD_LAT];
    assign push      = resp_vld & match_valid;
    assign drop      = resp_vld & ~match_valid;
    assign in_flight = |pipe_vld;
    assign pop       = pair_valid & pair_ready;

    assign arr_rd_en   = issue_r1 | issue_r2;
    assign arr_rd_addr = arr_rd_en ? row_cnt[num_qubit-1:0] : '0;
    assign busy        = (state != S_IDLE);
    assign pair_valid  = (fifo_cnt != '0);
    assign pair_first  = pair_valid ? fifo_mem[rd_ptr][ENT_W-1:num_qubit] : '0;
    assign pair_second = pair_valid ? fifo_mem[rd_ptr][num_qubit-1:0] : '0;

    // State register for the two-round sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and issue decode; in round two a row is issued only while credit remains.
    always_comb begin
        next_state = state;
        issue_r1   = 1'b0;
        issue_r2   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (num_clamped == '0) ? S_DONE : S_R1;
                end
            end
            S_R1: begin
                issue_r1 = 1'b1;
                if (last_row) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_alpha) begin
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                next_state = S_R2;
            end
            S_R2: begin
                if (credit != '0) begin
                    issue_r2 = 1'b1;
                    if (last_row) begin
                        next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_flight && (fifo_cnt == '0)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Latch the clamped row count and step the row counter once per issued row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_rows  <= '0;
            row_cnt <= '0;
        end else begin
            if (state == S_IDLE) begin
                row_cnt <= '0;
                if (start) begin
                    n_rows <= num_clamped;
                end
            end else if (issue_r1 || issue_r2) begin
                row_cnt <= last_row ? '0 : row_cnt + VW'(1);
            end
        end
    end

    // Round-tagged strobes to the index RAM controller, and the sweep_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_phase   <= 1'b0;
            rd_phase   <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            wr_phase   <= issue_r1;
            rd_phase   <= issue_r2;
            sweep_done <= (state == S_DONE);
        end
    end

    // Carry each round-two row alongside its read until the response comes back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe_row[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue_r2;
            pipe_row[0] <= row_cnt[num_qubit-1:0];
            for (int i = RD_LAT; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_row[i] <= pipe_row[i-1];
            end
        end
    end

    // Credit counts the FIFO slots that are neither filled nor claimed by a read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= CNT_W'(PAIR_DEPTH);
        end else begin
            credit <= credit + CNT_W'(pop) + CNT_W'(drop) - CNT_W'(issue_r2);
        end
    end

    // Pair FIFO storage; a push and a pop may share a cycle even when the FIFO is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < PAIR_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {match_index, pipe_row[RD_LAT]};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef PAIR_COUNT_EN
    // Count the pairs pushed this sweep; the value holds until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_count <= '0;
        end else if ((state == S_IDLE) && start) begin
            pair_count <= '0;
        end else if (push) begin
            pair_count <= pair_count + VW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_phase_pair_sequencer.sv
// Testbench for phase_pair_sequencer.
// The bench acts as the index RAM: it answers each round-two read RD_LAT cycles after rd_phase.
// Its answers come from random per-row match tables.
// A behavioural model tracks the rows, the pairs in order, the FIFO occupancy and the timing.
// Build with PAIR_COUNT_EN defined to also check pair_count.

module tb_phase_pair_sequencer;

    localparam int NQ    = 3;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int ROWS  = 1 << NQ;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NQ:0]   num_vec = '0;
    logic          done_alpha = 1'b0;
    logic          match_valid = 1'b0;
    logic [NQ-1:0] match_index = '0;
    logic          pair_ready = 1'b0;
    logic          arr_rd_en;
    logic [NQ-1:0] arr_rd_addr;
    logic          wr_phase;
    logic          rd_phase;
    logic          pair_valid;
    logic [NQ-1:0] pair_first;
    logic [NQ-1:0] pair_second;
    logic          busy;
    logic          sweep_done;
`ifdef PAIR_COUNT_EN
    logic [NQ:0]   pair_count;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int n_exp = 0;
    int n_pairs = 0;
    int r1_cnt = 0;
    int r2_cnt = 0;
    int pop_cnt = 0;
    int occ = 0;
    int inflight = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int first_r2_exp = 0;
    int ready_mode = 0;
    bit stray_en = 1'b0;
    bit prev_r1 = 1'b0;
    bit prev_r2 = 1'b0;
    bit cur_r1 = 1'b0;
    bit cur_r2 = 1'b0;
    bit match_tbl [ROWS];
    int idx_tbl [ROWS];
    int exp_first [ROWS];
    int exp_second [ROWS];
    int pend_due [$];
    int pend_row [$];

    phase_pair_sequencer #(
        .num_qubit (NQ),
        .PAIR_DEPTH(DEPTH),
        .RD_LAT    (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_vec    (num_vec),
        .done_alpha (done_alpha),
        .arr_rd_en  (arr_rd_en),
        .arr_rd_addr(arr_rd_addr),
        .wr_phase   (wr_phase),
        .rd_phase   (rd_phase),
        .match_valid(match_valid),
        .match_index(match_index),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_first (pair_first),
        .pair_second(pair_second),
        .busy       (busy),
        .sweep_done (sweep_done)
`ifdef PAIR_COUNT_EN
        ,
        .pair_count (pair_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Index RAM model: answer due reads, inject stray matches when enabled, drive consumer ready.
    initial forever begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            match_valid = 1'b0;
            pair_ready  = 1'b0;
        end else begin
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                match_valid = match_tbl[pend_row[0]];
                match_index = NQ'(idx_tbl[pend_row[0]]);
            end else if (stray_en) begin
                match_valid = 1'($urandom_range(0, 1));
                match_index = NQ'($urandom);
            end else begin
                match_valid = 1'b0;
                match_index = NQ'($urandom);
            end
            case (ready_mode)
                0:       pair_ready = 1'b0;
                1:       pair_ready = 1'b1;
                default: pair_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Mid-cycle observation: rows, timing, credit room, pair order and occupancy.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("pair_valid", int'(pair_valid), int'(occ != 0));
            checkOutput("wr_phase", int'(wr_phase), int'(prev_r1));
            checkOutput("rd_phase", int'(rd_phase), int'(prev_r2));
            cur_r1 = 1'b0;
            cur_r2 = 1'b0;
            if (arr_rd_en) begin
                if (r1_cnt < n_exp) begin
                    checkOutput("r1_addr", int'(arr_rd_addr), r1_cnt);
                    checkOutput("r1_cycle", cyc, start_cyc + 1 + r1_cnt);
                    r1_cnt++;
                    cur_r1 = 1'b1;
                end else begin
                    checkOutput("r2_addr", int'(arr_rd_addr), r2_cnt);
                    if (r2_cnt == 0) checkOutput("r2_start_cycle", cyc, first_r2_exp);
                    checkOutput("credit_room", int'(inflight + occ < DEPTH), 1);
                    r2_cnt++;
                    cur_r2 = 1'b1;
                    inflight++;
                    pend_due.push_back(cyc + 1 + LAT);
                    pend_row.push_back(int'(arr_rd_addr));
                end
            end
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                if (match_valid) occ++;
                inflight--;
                void'(pend_due.pop_front());
                void'(pend_row.pop_front());
            end
            if (pair_valid && pair_ready) begin
                if (pop_cnt < n_pairs) begin
                    checkOutput("pair_first", int'(pair_first), exp_first[pop_cnt]);
                    checkOutput("pair_second", int'(pair_second), exp_second[pop_cnt]);
                end else begin
                    checkOutput("pop_count", pop_cnt + 1, n_pairs);
                end
                pop_cnt++;
                occ--;
            end
            if (sweep_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_r1 = cur_r1;
            prev_r2 = cur_r2;
        end
    end

    // mmode: 0 random matches, 1 every row matches, 2 rows 1 and 3 match with indices 2 and 0.
    task automatic applyStimulus(input int nv, input int alpha_dly, input int rmode, input int mmode);
        int nn;
        int k;
        int alpha_rise;
        nn = (nv > ROWS) ? ROWS : nv;
        k = 0;
        for (int i = 0; i < ROWS; i++) begin
            case (mmode)
                1:       match_tbl[i] = 1'b1;
                2:       match_tbl[i] = (i == 1) || (i == 3);
                default: match_tbl[i] = 1'($urandom_range(0, 1));
            endcase
            idx_tbl[i] = (mmode == 2) ? ((i == 1) ? 2 : 0) : int'($urandom_range(0, ROWS - 1));
            if (i < nn && match_tbl[i]) begin
                exp_first[k]  = idx_tbl[i];
                exp_second[k] = i;
                k++;
            end
        end
        if (nn == 0) alpha_dly = -1;
        n_exp = nn;
        n_pairs = k;
        r1_cnt = 0;
        r2_cnt = 0;
        pop_cnt = 0;
        done_cnt = 0;
        ready_mode = rmode;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        alpha_rise = start_cyc + nn + alpha_dly;
        first_r2_exp = (alpha_dly < 0) ? start_cyc + nn + 3 : alpha_rise + 2;
        done_alpha = (alpha_dly < 0);
        num_vec = (NQ + 1)'(nv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        num_vec = (NQ + 1)'($urandom);
        if (alpha_dly >= 0) begin
            stray_en = 1'b1;
            while (cyc < alpha_rise) begin
                @(posedge clk);
                #1;
            end
            stray_en = 1'b0;
            done_alpha = 1'b1;
        end
    endtask

    task automatic waitSweep(input int limit);
        int g;
        g = 0;
        while (done_cnt == 0 && g < limit) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (n_exp == 0) checkOutput("zero_done_cycle", done_cyc, start_cyc + 2);
        stray_en = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        stray_en = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("r1_rows", r1_cnt, n_exp);
        checkOutput("r2_rows", r2_cnt, n_exp);
        checkOutput("pairs_popped", pop_cnt, n_pairs);
        checkOutput("idle_busy", int'(busy), 0);
`ifdef PAIR_COUNT_EN
        checkOutput("pair_count", int'(pair_count), n_pairs);
`endif
    endtask

    task automatic clearModel();
        pend_due.delete();
        pend_row.delete();
        occ = 0;
        inflight = 0;
        prev_r1 = 1'b0;
        prev_r2 = 1'b0;
        n_exp = 0;
        n_pairs = 0;
        r1_cnt = 0;
        r2_cnt = 0;
        pop_cnt = 0;
        done_cnt = 0;
    endtask

    // Directed scenarios first, then randomized sweeps.
    initial begin
        int g;
        #3;
        checkOutput("rst_arr_rd_en", int'(arr_rd_en), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_pair_valid", int'(pair_valid), 0);
        checkOutput("rst_sweep_done", int'(sweep_done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(4, -1, 1, 2);
        waitSweep(200);

        applyStimulus(4, 10, 1, 0);
        waitSweep(200);

        applyStimulus(0, -1, 1, 0);
        waitSweep(50);

        applyStimulus(15, -1, 2, 0);
        waitSweep(300);

        applyStimulus(8, -1, 0, 1);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        checkOutput("stall_r2_issues", r2_cnt, DEPTH);
        checkOutput("stall_pair_valid", int'(pair_valid), 1);
        checkOutput("stall_busy", int'(busy), 1);
        ready_mode = 1;
        waitSweep(200);

        applyStimulus(8, -1, 0, 1);
        g = 0;
        while (occ < 2 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        checkOutput("abort_fifo_loaded", int'(pair_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        clearModel();
        checkOutput("abort_arr_rd_en", int'(arr_rd_en), 0);
        checkOutput("abort_arr_rd_addr", int'(arr_rd_addr), 0);
        checkOutput("abort_wr_phase", int'(wr_phase), 0);
        checkOutput("abort_rd_phase", int'(rd_phase), 0);
        checkOutput("abort_pair_valid", int'(pair_valid), 0);
        checkOutput("abort_pair_first", int'(pair_first), 0);
        checkOutput("abort_pair_second", int'(pair_second), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_sweep_done", int'(sweep_done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abort_no_done", done_cnt, 0);
        checkOutput("abort_idle", int'(busy), 0);

        applyStimulus(5, -1, 1, 0);
        waitSweep(200);

        for (int t = 0; t < 15; t++) begin
            int nv;
            int dly;
            nv = int'($urandom_range(0, 15));
            dly = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 6));
            applyStimulus(nv, dly, 2, 0);
            waitSweep(400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
